axi_rd_mem_stub: RTL and testbench

Parametrised AXI read-slave memory model. It is the successor to the fixed single-latency RAM stub used behind prefetcherTop in system benches. It accepts multiple outstanding AR requests into an in-order queue and enforces a programmable minimum access latency per request. It returns INCR bursts on R with optional periodic backpressure bubbles and SLVERR for out-of-range words. Contents are preloaded through a backdoor write port; there is no AXI write path.

---
 rtl/axi_stub_pkg.sv | 26 ++
 rtl/axi_rd_mem_stub_if.sv | 32 +++
 rtl/axi_req_queue.sv | 65 ++++++
 rtl/axi_rd_mem_stub.sv | 198 +++++++++++++++++++
 tb/tb_axi_rd_mem_stub.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_stub_pkg.sv
// Shared types for the AXI read-slave memory stub: response codes, R-channel FSM states, request-queue entry.
// Latency: none (types and constants only).
// Backpressure: n/a.
package axi_stub_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Entry fields are sized for the widest configuration the stub supports;
    // narrower instances zero-extend on push and slice on pop.
    localparam int AR_ID_MAX   = 32;
    localparam int AR_ADDR_MAX = 64;
    localparam int AR_LEN_MAX  = 16;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } r_state_t;

    typedef struct packed {
        logic [AR_ID_MAX-1:0]   id;
        logic [AR_ADDR_MAX-1:0] addr;
        logic [AR_LEN_MAX-1:0]  len;
    } ar_entry_t;

endpackage

// File: rtl/axi_rd_mem_stub_if.sv
// AR/R channel bundle between a read master and the memory stub.
// Latency: none (wires only).
// Backpressure: valid/ready on both channels.
interface axi_rd_mem_stub_if #(
    parameter int ADDR_BITS       = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int TID_WIDTH       = 8,
    parameter int BURST_LEN_WIDTH = 8
);
    logic                       s_ar_valid;
    logic                       s_ar_ready;
    logic [ADDR_BITS-1:0]       s_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] s_ar_len;
    logic [TID_WIDTH-1:0]       s_ar_id;
    logic                       s_r_valid;
    logic                       s_r_ready;
    logic [DATA_WIDTH-1:0]      s_r_data;
    logic [TID_WIDTH-1:0]       s_r_id;
    logic                       s_r_last;
    logic [1:0]                 s_r_resp;

    modport master (
        output s_ar_valid, s_ar_addr, s_ar_len, s_ar_id, s_r_ready,
        input  s_ar_ready, s_r_valid, s_r_data, s_r_id, s_r_last, s_r_resp
    );

    modport slave (
        input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_id, s_r_ready,
        output s_ar_ready, s_r_valid, s_r_data, s_r_id, s_r_last, s_r_resp
    );

endinterface

// File: rtl/axi_req_queue.sv
// In-order AR request FIFO with a saturating age counter per slot; head is eligible once its age reaches cfg_latency.
// Latency: a pushed entry is visible at the head the next cycle with age 0.
// Backpressure: caller must not push when count == depth; push and pop in one cycle keep count unchanged.
module axi_req_queue
    import axi_stub_pkg::*;
#(
    parameter int LOG_DEPTH = 2,
    parameter int LAT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  ar_entry_t            push_dat,
    input  logic                 pop,
    input  logic [LAT_WIDTH-1:0] cfg_latency,
    output ar_entry_t            head_dat,
    output logic                 head_eligible,
    output logic [LOG_DEPTH:0]   count
);
    localparam int DEPTH = 2**LOG_DEPTH;

    ar_entry_t            r_ent [DEPTH];
    logic [LAT_WIDTH-1:0] r_age [DEPTH];
    logic [LOG_DEPTH-1:0] r_wr_ptr;
    logic [LOG_DEPTH-1:0] r_rd_ptr;
    logic [LOG_DEPTH:0]   r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push && !pop)      r_count <= r_count + 1'b1;
            else if (pop && !push) r_count <= r_count - 1'b1;
        end
    end

    // Slot storage: a push clears that slot's age, every other slot ages and saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (r_wr_ptr == LOG_DEPTH'(i))) begin
                    r_ent[i] <= push_dat;
                    r_age[i] <= '0;
                end else if (r_age[i] != '1) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    assign head_dat      = r_ent[r_rd_ptr];
    assign head_eligible = (r_count != '0) && (r_age[r_rd_ptr] >= cfg_latency);
    assign count         = r_count;

endmodule

// File: rtl/axi_rd_mem_stub.sv
// AXI read-slave memory model: queued AR requests, programmable minimum latency, INCR bursts with optional stall bubbles.
// Latency: AR handshake in cycle T gives first R beat in cycle T+2+cfg_latency when idle; bursts chain without gaps.
// Backpressure: s_ar_ready drops when the queue is full; R beats hold stable until s_r_ready.
module axi_rd_mem_stub
    import axi_stub_pkg::*;
#(
    parameter int ADDR_BITS       = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int TID_WIDTH       = 8,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int LOG_OUTSTANDING = 2,
    parameter int LOG_MEM_DEPTH   = 10,
    parameter int LAT_WIDTH       = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    axi_rd_mem_stub_if.slave           s_axi,
    input  logic                       bd_wr_en,
    input  logic [LOG_MEM_DEPTH-1:0]   bd_wr_addr,
    input  logic [DATA_WIDTH-1:0]      bd_wr_data,
    input  logic [LAT_WIDTH-1:0]       cfg_latency,
    input  logic [LAT_WIDTH-1:0]       cfg_stall_period,
    output logic [LOG_OUTSTANDING:0]   outstanding
);
    // Word index width; assumes WORD_BITS >= LOG_MEM_DEPTH.
    localparam int BYTE_SH   = $clog2(DATA_WIDTH/8);
    localparam int WORD_BITS = ADDR_BITS - BYTE_SH;
    localparam int MEM_DEPTH = 2**LOG_MEM_DEPTH;
    localparam int QDEPTH    = 2**LOG_OUTSTANDING;

    logic [DATA_WIDTH-1:0]      r_mem [MEM_DEPTH];
    r_state_t                   r_state;
    r_state_t                   w_state_nxt;
    logic                       r_valid;
    logic [DATA_WIDTH-1:0]      r_data;
    logic [TID_WIDTH-1:0]       r_id;
    logic                       r_last;
    logic [1:0]                 r_resp;
    logic [WORD_BITS-1:0]       r_word;
    logic [BURST_LEN_WIDTH-1:0] r_cnt;
    logic [LAT_WIDTH-1:0]       r_stall_cnt;

    ar_entry_t                  w_push_dat;
    ar_entry_t                  w_head;
    logic                       w_head_elig;
    logic [LOG_OUTSTANDING:0]   w_count;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_hs;
    logic                       w_stall_hit;
    logic                       w_launch;
    logic                       w_clr_valid;
    logic                       w_adv;
    logic                       w_oor;
    logic [WORD_BITS-1:0]       w_head_word;
    logic [WORD_BITS-1:0]       w_ld_word;
    logic [BURST_LEN_WIDTH-1:0] w_ld_cnt;
    logic [TID_WIDTH-1:0]       w_ld_id;
    logic [LOG_MEM_DEPTH-1:0]   w_mem_idx;
    logic                       w_unused_head;

    assign s_axi.s_ar_ready = (w_count != (LOG_OUTSTANDING+1)'(QDEPTH));
    assign w_push           = s_axi.s_ar_valid && s_axi.s_ar_ready;
    assign outstanding      = w_count;

    // Zero-extend the AR fields into the shared entry layout.
    always_comb begin
        w_push_dat      = '0;
        w_push_dat.id   = AR_ID_MAX'(s_axi.s_ar_id);
        w_push_dat.addr = AR_ADDR_MAX'(s_axi.s_ar_addr);
        w_push_dat.len  = AR_LEN_MAX'(s_axi.s_ar_len);
    end

    axi_req_queue #(
        .LOG_DEPTH (LOG_OUTSTANDING),
        .LAT_WIDTH (LAT_WIDTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .push          (w_push),
        .push_dat      (w_push_dat),
        .pop           (w_pop),
        .cfg_latency   (cfg_latency),
        .head_dat      (w_head),
        .head_eligible (w_head_elig),
        .count         (w_count)
    );

    assign w_head_word   = WORD_BITS'(w_head.addr[ADDR_BITS-1:0] >> BYTE_SH);
    assign w_unused_head = ^w_head;

    assign w_hs        = r_valid && s_axi.s_r_ready;
    assign w_stall_hit = (cfg_stall_period != '0) &&
                         (((LAT_WIDTH+1)'(r_stall_cnt) + (LAT_WIDTH+1)'(1)) >= (LAT_WIDTH+1)'(cfg_stall_period));

    // Backdoor preload port; no reset on the array.
    always_ff @(posedge clk) begin
        if (bd_wr_en) r_mem[bd_wr_addr] <= bd_wr_data;
    end

    // R FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and beat-launch decisions; a beat with r_valid low in BURST is a pending relaunch after a stall bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_launch    = 1'b0;
        w_clr_valid = 1'b0;
        w_ld_word   = r_word;
        w_ld_cnt    = r_cnt;
        w_ld_id     = r_id;
        case (r_state)
            ST_IDLE: begin
                if (w_head_elig) begin
                    w_pop       = 1'b1;
                    w_launch    = 1'b1;
                    w_ld_word   = w_head_word;
                    w_ld_cnt    = w_head.len[BURST_LEN_WIDTH-1:0];
                    w_ld_id     = w_head.id[TID_WIDTH-1:0];
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!r_valid) begin
                    w_launch = 1'b1;
                end else if (w_hs) begin
                    if (r_last) begin
                        if (w_head_elig && !w_stall_hit) begin
                            w_pop     = 1'b1;
                            w_launch  = 1'b1;
                            w_ld_word = w_head_word;
                            w_ld_cnt  = w_head.len[BURST_LEN_WIDTH-1:0];
                            w_ld_id   = w_head.id[TID_WIDTH-1:0];
                        end else begin
                            w_clr_valid = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_ld_word = r_word + 1'b1;
                        w_ld_cnt  = r_cnt - 1'b1;
                        if (w_stall_hit) w_clr_valid = 1'b1;
                        else             w_launch    = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_adv     = w_launch || (w_hs && !r_last);
    assign w_oor     = (w_ld_word >> LOG_MEM_DEPTH) != '0;
    assign w_mem_idx = w_ld_word[LOG_MEM_DEPTH-1:0];

    // Beat registers: memory is sampled at launch and held until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_last  <= 1'b0;
            r_resp  <= RESP_OKAY;
            r_word  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_adv) begin
                r_word <= w_ld_word;
                r_cnt  <= w_ld_cnt;
            end
            if (w_launch) begin
                r_valid <= 1'b1;
                r_id    <= w_ld_id;
                r_last  <= (w_ld_cnt == '0);
                r_resp  <= w_oor ? RESP_SLVERR : RESP_OKAY;
                r_data  <= w_oor ? '0 : r_mem[w_mem_idx];
            end else if (w_clr_valid) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Accepted-beat counter for stall bubbles; spans burst boundaries and idles at zero when stalling is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           r_stall_cnt <= '0;
        else if (cfg_stall_period == '0)   r_stall_cnt <= '0;
        else if (w_hs)                     r_stall_cnt <= w_stall_hit ? '0 : r_stall_cnt + 1'b1;
    end

    assign s_axi.s_r_valid = r_valid;
    assign s_axi.s_r_data  = r_data;
    assign s_axi.s_r_id    = r_id;
    assign s_axi.s_r_last  = r_last;
    assign s_axi.s_r_resp  = r_resp;

endmodule

// File: tb/tb_axi_rd_mem_stub.sv
// Directed bench for axi_rd_mem_stub with a beat-level scoreboard and stability monitor.
// Latency: checks first-beat timing and inter-beat spacing per scenario.
// Backpressure: exercises s_r_ready toggling, stall bubbles and a full request queue.
module tb_axi_rd_mem_stub;

    localparam int ADDR_BITS       = 16;
    localparam int DATA_WIDTH      = 8;
    localparam int TID_WIDTH       = 8;
    localparam int BURST_LEN_WIDTH = 8;
    localparam int LOG_OUTSTANDING = 2;
    localparam int LOG_MEM_DEPTH   = 10;
    localparam int LAT_WIDTH       = 6;

    typedef struct {
        logic [7:0] data;
        logic [7:0] id;
        logic       last;
        logic [1:0] resp;
        int         cyc;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       bd_wr_en;
    logic [9:0] bd_wr_addr;
    logic [7:0] bd_wr_data;
    logic [5:0] cfg_latency;
    logic [5:0] cfg_stall_period;
    logic [2:0] outstanding;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    ar_log[$];
    logic [7:0] model_mem [1024];

    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic [7:0] p_data = '0;
    logic [7:0] p_id = '0;
    logic       p_last = 1'b0;
    logic [1:0] p_resp = '0;

    int   stall_offs[6] = '{0, 1, 3, 4, 6, 7};
    logic [7:0] oor_data[4] = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    logic [1:0] oor_resp[4] = '{2'b00, 2'b00, 2'b10, 2'b10};

    axi_rd_mem_stub_if #(
        .ADDR_BITS(ADDR_BITS), .DATA_WIDTH(DATA_WIDTH),
        .TID_WIDTH(TID_WIDTH), .BURST_LEN_WIDTH(BURST_LEN_WIDTH)
    ) axi ();

    axi_rd_mem_stub #(
        .ADDR_BITS(ADDR_BITS), .DATA_WIDTH(DATA_WIDTH), .TID_WIDTH(TID_WIDTH),
        .BURST_LEN_WIDTH(BURST_LEN_WIDTH), .LOG_OUTSTANDING(LOG_OUTSTANDING),
        .LOG_MEM_DEPTH(LOG_MEM_DEPTH), .LAT_WIDTH(LAT_WIDTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axi            (axi),
        .bd_wr_en         (bd_wr_en),
        .bd_wr_addr       (bd_wr_addr),
        .bd_wr_data       (bd_wr_data),
        .cfg_latency      (cfg_latency),
        .cfg_stall_period (cfg_stall_period),
        .outstanding      (outstanding)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: an accepted AR expands into its full list of expected beats from the memory image.
    task automatic mon_step();
        beat_t e;
        beat_t g;
        logic [15:0] w;
        if (rst) begin
            exp_q.delete();
            p_valid = 1'b0;
            return;
        end
        if (p_valid && !p_ready)
            chk("r_hold_stable",
                32'({axi.s_r_valid, axi.s_r_data, axi.s_r_id, axi.s_r_last, axi.s_r_resp}),
                32'({1'b1, p_data, p_id, p_last, p_resp}));
        if (axi.s_ar_valid && axi.s_ar_ready) begin
            ar_log.push_back(cyc);
            for (int i = 0; i <= int'(axi.s_ar_len); i++) begin
                w      = axi.s_ar_addr + 16'(i);
                e.id   = axi.s_ar_id;
                e.last = (i == int'(axi.s_ar_len));
                e.cyc  = 0;
                if (w >= 16'd1024) begin
                    e.data = 8'h00;
                    e.resp = 2'b10;
                end else begin
                    e.data = model_mem[w[9:0]];
                    e.resp = 2'b00;
                end
                exp_q.push_back(e);
            end
        end
        if (axi.s_r_valid && axi.s_r_ready) begin
            g.data = axi.s_r_data;
            g.id   = axi.s_r_id;
            g.last = axi.s_r_last;
            g.resp = axi.s_r_resp;
            g.cyc  = cyc;
            got_q.push_back(g);
            chk("r_beat_was_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("r_beat_fields", 32'({g.data, g.id, g.last, g.resp}),
                    32'({e.data, e.id, e.last, e.resp}));
            end
        end
        p_valid = axi.s_r_valid;
        p_ready = axi.s_r_ready;
        p_data  = axi.s_r_data;
        p_id    = axi.s_r_id;
        p_last  = axi.s_r_last;
        p_resp  = axi.s_r_resp;
    endtask

    always @(negedge clk) mon_step();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [9:0] a, input logic [7:0] d);
        bd_wr_en   = 1'b1;
        bd_wr_addr = a;
        bd_wr_data = d;
        step();
        bd_wr_en     = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic do_ar(input logic [15:0] addr, input logic [7:0] len, input logic [7:0] id);
        bit ok;
        ok = 1'b0;
        axi.s_ar_valid = 1'b1;
        axi.s_ar_addr  = addr;
        axi.s_ar_len   = len;
        axi.s_ar_id    = id;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (axi.s_ar_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ar_accept_timeout", 32'(ok), 32'd1);
        step();
        axi.s_ar_valid = 1'b0;
    endtask

    task automatic wait_beats(input string name, input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (got_q.size() >= n) break;
        end
        repeat (4) @(negedge clk);
        chk(name, 32'(got_q.size()), 32'(n));
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        step();
    endtask

    task automatic start_test();
        got_q.delete();
        ar_log.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 50000", cyc);
        $fatal(1);
    end

    initial begin
        bit seen;
        rst              = 1'b1;
        bd_wr_en         = 1'b0;
        bd_wr_addr       = '0;
        bd_wr_data       = '0;
        cfg_latency      = '0;
        cfg_stall_period = '0;
        axi.s_ar_valid   = 1'b0;
        axi.s_ar_addr    = '0;
        axi.s_ar_len     = '0;
        axi.s_ar_id      = '0;
        axi.s_r_ready    = 1'b1;
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_r_valid", 32'(axi.s_r_valid), 32'd0);
        chk("rst_r_last", 32'(axi.s_r_last), 32'd0);
        chk("rst_r_resp", 32'(axi.s_r_resp), 32'd0);
        chk("rst_r_data", 32'(axi.s_r_data), 32'd0);
        chk("rst_r_id", 32'(axi.s_r_id), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ar_ready", 32'(axi.s_ar_ready), 32'd1);
        step();

        for (int i = 0; i < 100; i++) bd_write(10'(i), 8'(i));
        bd_write(10'd1022, 8'hA5);
        bd_write(10'd1023, 8'h5A);

        // Zero latency, single 4-beat burst
        start_test();
        do_ar(16'h0005, 8'd3, 8'd5);
        wait_beats("t1_beats", 4, 50);
        if (got_q.size() == 4 && ar_log.size() == 1) begin
            chk("t1_first_latency", 32'(got_q[0].cyc - ar_log[0]), 32'd2);
            chk("t1_id", 32'(got_q[0].id), 32'd5);
            for (int i = 0; i < 4; i++) begin
                chk("t1_data", 32'(got_q[i].data), 32'(5 + i));
                chk("t1_last", 32'(got_q[i].last), 32'(i == 3));
                chk("t1_resp", 32'(got_q[i].resp), 32'd0);
            end
        end

        // Latency 10, queue filled by four back-to-back single-beat ARs
        start_test();
        cfg_latency = 6'd10;
        do_ar(16'd0, 8'd0, 8'd1);
        do_ar(16'd3, 8'd0, 8'd2);
        do_ar(16'd6, 8'd0, 8'd3);
        do_ar(16'd9, 8'd0, 8'd4);
        @(negedge clk);
        chk("t2_ar_ready_full", 32'(axi.s_ar_ready), 32'd0);
        chk("t2_outstanding_full", 32'(outstanding), 32'd4);
        step();
        wait_beats("t2_beats", 4, 100);
        if (got_q.size() == 4 && ar_log.size() == 4) begin
            chk("t2_first_latency", 32'(got_q[0].cyc - ar_log[0]), 32'd12);
            for (int i = 0; i < 4; i++) begin
                chk("t2_spacing", 32'(got_q[i].cyc - got_q[0].cyc), 32'(i));
                chk("t2_data", 32'(got_q[i].data), 32'(3 * i));
            end
        end
        cfg_latency = 6'd0;

        // Ready toggled 1-0-0-1 during a 3-beat burst
        start_test();
        do_ar(16'd20, 8'd2, 8'd7);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (axi.s_r_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t3_valid_seen", 32'(seen), 32'd1);
        step();
        axi.s_r_ready = 1'b0;
        repeat (2) step();
        axi.s_r_ready = 1'b1;
        wait_beats("t3_beats", 3, 50);
        if (got_q.size() == 3) begin
            chk("t3_off1", 32'(got_q[1].cyc - got_q[0].cyc), 32'd3);
            chk("t3_off2", 32'(got_q[2].cyc - got_q[0].cyc), 32'd4);
            for (int i = 0; i < 3; i++) begin
                chk("t3_data", 32'(got_q[i].data), 32'(20 + i));
                chk("t3_last", 32'(got_q[i].last), 32'(i == 2));
            end
        end

        // Stall bubble after every second beat
        start_test();
        cfg_stall_period = 6'd2;
        do_ar(16'd30, 8'd5, 8'd8);
        wait_beats("t4_beats", 6, 60);
        if (got_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("t4_offset", 32'(got_q[i].cyc - got_q[0].cyc), 32'(stall_offs[i]));
                chk("t4_data", 32'(got_q[i].data), 32'(30 + i));
            end
        end
        cfg_stall_period = 6'd0;

        // Burst crossing the top of memory
        start_test();
        do_ar(16'd1022, 8'd3, 8'd9);
        wait_beats("t5_beats", 4, 50);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t5_data", 32'(got_q[i].data), 32'(oor_data[i]));
                chk("t5_resp", 32'(got_q[i].resp), 32'(oor_resp[i]));
                chk("t5_last", 32'(got_q[i].last), 32'(i == 3));
            end
        end

        // Reset mid-burst with two entries queued
        start_test();
        do_ar(16'd40, 8'd15, 8'd10);
        do_ar(16'd0, 8'd0, 8'd11);
        do_ar(16'd1, 8'd0, 8'd12);
        @(negedge clk);
        chk("t6_outstanding_before", 32'(outstanding), 32'd2);
        chk("t6_valid_before", 32'(axi.s_r_valid), 32'd1);
        step();
        rst = 1'b1;
        #2;
        chk("t6_valid_async_drop", 32'(axi.s_r_valid), 32'd0);
        chk("t6_outstanding_flush", 32'(outstanding), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ar_ready_after", 32'(axi.s_ar_ready), 32'd1);
        chk("t6_outstanding_after", 32'(outstanding), 32'd0);
        chk("t6_valid_after", 32'(axi.s_r_valid), 32'd0);
        step();
        start_test();
        do_ar(16'd50, 8'd1, 8'd13);
        wait_beats("t6_post_beats", 2, 50);
        if (got_q.size() == 2) begin
            chk("t6_post_data0", 32'(got_q[0].data), 32'd50);
            chk("t6_post_data1", 32'(got_q[1].data), 32'd51);
            chk("t6_post_id", 32'(got_q[1].id), 32'd13);
            chk("t6_post_last", 32'({got_q[0].last, got_q[1].last}), 32'b01);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
